hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use and mul/div
// stall detection, branch flush, and a fixed-latency mul/div tracker.
module hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned RA_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic            id_valid,
    input  logic            id_wreg,
    input  logic            id_is_md,
    input  logic [RA_W-1:0] id_rd,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            ex_wreg,
    input  logic            mem_wreg,
    input  logic            ex_is_load,
    input  logic            branch_taken,
    output logic [1:0]      qa_sel,
    output logic [1:0]      qb_sel,
    output logic            pc_stall,
    output logic            ifid_stall,
    output logic            idex_bubble,
    output logic            ifid_flush,
    output logic            md_busy,
    output logic            md_wb,
    output logic [RA_W-1:0] md_rd
);

    localparam int unsigned CW = $clog2(MD_LATENCY + 1);

    logic [CW-1:0]   r_cnt;
    logic [RA_W-1:0] r_md_rd;

    logic w_busy, w_wb, w_pend;
    logic w_ex1, w_ex2, w_mem1, w_mem2, w_md1, w_md2;
    logic w_load_use, w_md_raw, w_md_waw, w_md_struct;
    logic w_stall, w_issue;

    function automatic logic f_match(input logic            u,
                                     input logic            we,
                                     input logic [RA_W-1:0] src,
                                     input logic [RA_W-1:0] dst);
        return u & we & (src == dst) & (src != '0);
    endfunction

    assign w_busy = (r_cnt != '0);
    assign w_wb   = (r_cnt == CW'(1));
    assign w_pend = w_busy & ~w_wb;

    assign w_ex1  = f_match(id_use1, ex_wreg,  id_rs1, ex_rd);
    assign w_ex2  = f_match(id_use2, ex_wreg,  id_rs2, ex_rd);
    assign w_mem1 = f_match(id_use1, mem_wreg, id_rs1, mem_rd);
    assign w_mem2 = f_match(id_use2, mem_wreg, id_rs2, mem_rd);
    // The MD result is only forwardable on its writeback cycle.
    assign w_md1  = f_match(id_use1, w_wb, id_rs1, r_md_rd);
    assign w_md2  = f_match(id_use2, w_wb, id_rs2, r_md_rd);

    always_comb begin
        qa_sel = 2'b00;
        if (w_ex1)       qa_sel = 2'b01;
        else if (w_mem1) qa_sel = 2'b10;
        else if (w_md1)  qa_sel = 2'b11;
    end

    always_comb begin
        qb_sel = 2'b00;
        if (w_ex2)       qb_sel = 2'b01;
        else if (w_mem2) qb_sel = 2'b10;
        else if (w_md2)  qb_sel = 2'b11;
    end

    assign w_load_use  = ex_is_load & (w_ex1 | w_ex2);
    assign w_md_raw    = w_pend & (r_md_rd != '0) &
                         ((id_use1 & (id_rs1 == r_md_rd)) | (id_use2 & (id_rs2 == r_md_rd)));
    assign w_md_waw    = w_pend & id_wreg & (id_rd == r_md_rd);
    assign w_md_struct = w_pend & id_is_md;
    assign w_stall     = id_valid & (w_load_use | w_md_raw | w_md_waw | w_md_struct);
    assign w_issue     = id_valid & id_is_md & ~w_stall & ~branch_taken;

    always_comb begin
        pc_stall    = w_stall;
        ifid_stall  = w_stall;
        idex_bubble = w_stall;
        ifid_flush  = 1'b0;
        if (branch_taken) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_md_rd <= '0;
        end else if (w_issue) begin
            r_cnt   <= CW'(MD_LATENCY);
            r_md_rd <= id_rd;
        end else if (w_busy) begin
            r_cnt   <= r_cnt - CW'(1);
        end
    end

    assign md_busy = w_busy;
    assign md_wb   = w_wb;
    assign md_rd   = r_md_rd;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a timeline model of the
// mul/div unit (issue edge + fixed latency) and rule-based hazard/forward checks.
module tb_hazard_ctrl;

    localparam int L = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, id_rd, ex_rd, mem_rd;
    logic       id_use1, id_use2, id_valid, id_wreg, id_is_md;
    logic       ex_wreg, mem_wreg, ex_is_load, branch_taken;
    logic [1:0] qa_sel, qb_sel;
    logic       pc_stall, ifid_stall, idex_bubble, ifid_flush, md_busy, md_wb;
    logic [4:0] md_rd;

    hazard_ctrl #(.MD_LATENCY(L), .RA_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_valid(id_valid), .id_wreg(id_wreg), .id_is_md(id_is_md), .id_rd(id_rd),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_wreg(ex_wreg), .mem_wreg(mem_wreg),
        .ex_is_load(ex_is_load), .branch_taken(branch_taken),
        .qa_sel(qa_sel), .qb_sel(qb_sel), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .md_busy(md_busy), .md_wb(md_wb), .md_rd(md_rd)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model: cycle c is the period following edge c; an issue at edge E makes
    // the unit busy for cycles E..E+L-1, writing back in the last of them.
    int         cyc   = 0;
    bit         m_act = 0;
    int         m_iss = 0;
    logic [4:0] m_rd  = '0;
    bit         e_issue;

    task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    endtask

    function automatic bit m_busy();
        return m_act && (cyc - m_iss) >= 0 && (cyc - m_iss) < L;
    endfunction

    function automatic bit m_wb();
        return m_act && (cyc - m_iss) == L - 1;
    endfunction

    function automatic bit prod(input bit u, input bit we, input logic [4:0] rs, input logic [4:0] rd);
        return u && we && rs == rd && rs != 0;
    endfunction

    function automatic logic [1:0] exp_sel(input logic [4:0] rs, input bit u);
        if (prod(u, ex_wreg, rs, ex_rd))   return 2'b01;
        if (prod(u, mem_wreg, rs, mem_rd)) return 2'b10;
        if (prod(u, m_wb(), rs, m_rd))     return 2'b11;
        return 2'b00;
    endfunction

    task automatic sample();
        bit pend, hz, stall, br;
        @(negedge clk);
        pend  = m_busy() && !m_wb();
        hz    = (ex_is_load && (prod(id_use1, ex_wreg, id_rs1, ex_rd) || prod(id_use2, ex_wreg, id_rs2, ex_rd)))
             || (pend && m_rd != 0 && ((id_use1 && id_rs1 == m_rd) || (id_use2 && id_rs2 == m_rd)))
             || (pend && id_wreg && id_rd == m_rd)
             || (pend && id_is_md);
        stall = id_valid && hz;
        br    = branch_taken;
        e_issue = id_valid && id_is_md && !stall && !br;
        chk("qa_sel", 8'(qa_sel), 8'(exp_sel(id_rs1, id_use1)));
        chk("qb_sel", 8'(qb_sel), 8'(exp_sel(id_rs2, id_use2)));
        chk("pc_stall", 8'(pc_stall), 8'(stall && !br));
        chk("ifid_stall", 8'(ifid_stall), 8'(stall && !br));
        chk("idex_bubble", 8'(idex_bubble), 8'(stall || br));
        chk("ifid_flush", 8'(ifid_flush), 8'(br));
        chk("md_busy", 8'(md_busy), 8'(m_busy()));
        chk("md_wb", 8'(md_wb), 8'(m_wb()));
        chk("md_rd", 8'(md_rd), 8'(m_rd));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_act = 0;
            m_rd  = '0;
        end else if (e_issue) begin
            m_act = 1;
            m_iss = cyc + 1;
            m_rd  = id_rd;
        end
        cyc++;
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic idle();
        rst = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; ex_rd = 0; mem_rd = 0;
        id_use1 = 0; id_use2 = 0; id_valid = 0; id_wreg = 0; id_is_md = 0;
        ex_wreg = 0; mem_wreg = 0; ex_is_load = 0; branch_taken = 0;
    endtask

    task automatic issue_md(input logic [4:0] rd);
        idle();
        id_valid = 1; id_is_md = 1; id_wreg = 1; id_rd = rd;
    endtask

    initial begin
        idle();
        rst = 1;
        e_issue = 0;
        advance();

        // Reset with idle inputs
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("rst_qa", 8'(qa_sel), 8'd0);
            chk("rst_busy", 8'(md_busy), 8'd0);
            advance();
        end
        rst = 0;
        cycle();

        // Forwarding priority
        ex_rd = 5; ex_wreg = 1; mem_rd = 5; mem_wreg = 1; id_rs1 = 5; id_use1 = 1;
        sample(); chk("fwd_ex", 8'(qa_sel), 8'b01); advance();
        ex_rd = 0;
        sample(); chk("fwd_mem", 8'(qa_sel), 8'b10); advance();
        id_rs1 = 0;
        sample(); chk("fwd_x0", 8'(qa_sel), 8'b00); advance();

        // Load-use stall then forward from MEM
        idle();
        ex_is_load = 1; ex_wreg = 1; ex_rd = 7; id_rs2 = 7; id_use2 = 1; id_valid = 1;
        sample(); chk("lu_stall", 8'(pc_stall), 8'd1); advance();
        ex_is_load = 0; ex_wreg = 0; ex_rd = 0; mem_rd = 7; mem_wreg = 1;
        sample(); chk("lu_memfwd", 8'(qb_sel), 8'b10); chk("lu_nostall", 8'(pc_stall), 8'd0); advance();

        // MD issue and dependent instruction
        issue_md(9);
        cycle();
        idle();
        id_valid = 1; id_use1 = 1; id_rs1 = 9; id_wreg = 1; id_rd = 3;
        for (int i = 0; i < L - 1; i++) begin
            sample(); chk("md_raw_stall", 8'(pc_stall), 8'd1); advance();
        end
        sample();
        chk("md_raw_go", 8'(pc_stall), 8'd0);
        chk("md_fwd", 8'(qa_sel), 8'b11);
        chk("md_wb_pulse", 8'(md_wb), 8'd1);
        advance();
        idle();
        sample(); chk("md_idle", 8'(md_busy), 8'd0); advance();

        // Back-to-back MD
        issue_md(10);
        cycle();
        issue_md(11);
        for (int i = 0; i < L - 1; i++) begin
            sample(); chk("b2b_stall", 8'(pc_stall), 8'd1); advance();
        end
        sample(); chk("b2b_wb1", 8'(md_wb), 8'd1); chk("b2b_go", 8'(pc_stall), 8'd0); advance();
        idle();
        for (int i = 0; i < L; i++) begin
            sample(); chk("b2b_busy", 8'(md_busy), 8'd1); chk("b2b_rd", 8'(md_rd), 8'd11); advance();
        end
        cycle();

        // Branch overrides load-use stall; in-flight MD unaffected; flushed MD not issued
        issue_md(12);
        cycle();
        idle();
        ex_is_load = 1; ex_wreg = 1; ex_rd = 7; id_rs2 = 7; id_use2 = 1; id_valid = 1;
        id_is_md = 1; id_rd = 20; branch_taken = 1;
        sample();
        chk("br_flush", 8'(ifid_flush), 8'd1);
        chk("br_bubble", 8'(idex_bubble), 8'd1);
        chk("br_pcstall", 8'(pc_stall), 8'd0);
        advance();
        idle();
        for (int i = 1; i < L; i++) cycle();
        sample(); chk("br_md_done", 8'(md_busy), 8'd0); chk("br_md_rd", 8'(md_rd), 8'd12); advance();

        // Reset during MD operation
        issue_md(13);
        cycle();
        idle();
        id_valid = 1; id_use1 = 1; id_rs1 = 13;
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        for (int i = 0; i < L; i++) begin
            sample();
            chk("rst_md_busy", 8'(md_busy), 8'd0);
            chk("rst_md_wb", 8'(md_wb), 8'd0);
            chk("rst_dep_go", 8'(pc_stall), 8'd0);
            advance();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 49) == 0);
            id_rs1       = 5'($urandom_range(0, 7));
            id_rs2       = 5'($urandom_range(0, 7));
            id_rd        = 5'($urandom_range(0, 7));
            ex_rd        = 5'($urandom_range(0, 7));
            mem_rd       = 5'($urandom_range(0, 7));
            id_use1      = 1'($urandom);
            id_use2      = 1'($urandom);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_wreg      = 1'($urandom);
            id_is_md     = ($urandom_range(0, 3) == 0);
            ex_wreg      = 1'($urandom);
            mem_wreg     = 1'($urandom);
            ex_is_load   = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
